// File: rtl/week6_ex1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant outputs).
interface week6_ex1_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   modport master (
      output req,
      input  grant,
      input  grant_idx,
      input  grant_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output grant,
      output grant_idx,
      output grant_valid,
      output timeout
   );
endinterface

// File: rtl/week6_ex1_rr_arbiter.sv
// Four-way round-robin arbiter with grant hold; optional hold limit via HOLD_LIMIT_EN.
// Latency: 1 cycle from req to grant; owner keeps grant while requesting.
// Backpressure: none, requesters simply hold req until granted.
module week6_ex1_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   week6_ex1_rr_arbiter_if.slave   bus
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [1:0]       r_last, w_last_nxt;
   logic             r_valid, w_valid_nxt;
   logic [CNT_W-1:0] r_hold, w_hold_nxt;
   logic [1:0]       w_pick_idle, w_pick_rot;
   logic [3:0]       w_others;
   logic [3:0]       w_grant;

`ifdef HOLD_LIMIT_EN
   localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
   logic r_timeout, w_timeout_nxt;
`else
   localparam logic [CNT_W-1:0] HOLD_SAT = {CNT_W{1'b1}};
`endif

   // First set bit searching upward from base+1; falls back to base itself.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
      logic [1:0] sel;
      sel = base;
      for (int k = 3; k >= 1; k--) begin
         if (req[base + 2'(k)]) sel = base + 2'(k);
      end
      return sel;
   endfunction

   assign w_pick_idle = rr_pick(bus.req, r_last);
   assign w_pick_rot  = rr_pick(bus.req, r_idx);
   assign w_others    = bus.req & ~(4'b0001 << r_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 2'b00;
         r_last  <= 2'b11;
         r_valid <= 1'b0;
         r_hold  <= '0;
`ifdef HOLD_LIMIT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
         r_valid <= w_valid_nxt;
         r_hold  <= w_hold_nxt;
`ifdef HOLD_LIMIT_EN
         r_timeout <= w_timeout_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      w_valid_nxt = r_valid;
      w_hold_nxt  = r_hold;
`ifdef HOLD_LIMIT_EN
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (|bus.req) begin
               w_state_nxt = S_GRANT;
               w_idx_nxt   = w_pick_idle;
               w_last_nxt  = w_pick_idle;
               w_valid_nxt = 1'b1;
               w_hold_nxt  = CNT_W'(1);
            end
         end
         S_GRANT: begin
            if (bus.req[r_idx]) begin
`ifdef HOLD_LIMIT_EN
               // Owner exceeded its budget and someone else is waiting: hand over.
               if ((r_hold == HOLD_SAT) && (|w_others)) begin
                  w_idx_nxt     = w_pick_rot;
                  w_last_nxt    = w_pick_rot;
                  w_hold_nxt    = CNT_W'(1);
                  w_timeout_nxt = 1'b1;
               end else if (r_hold != HOLD_SAT) begin
                  w_hold_nxt = r_hold + CNT_W'(1);
               end
`else
               if (r_hold != HOLD_SAT) w_hold_nxt = r_hold + CNT_W'(1);
`endif
            end else if (|w_others) begin
               w_idx_nxt  = w_pick_rot;
               w_last_nxt = w_pick_rot;
               w_hold_nxt = CNT_W'(1);
            end else begin
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
               w_hold_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_grant = 4'b0000;
      if (r_valid) w_grant[r_idx] = 1'b1;
   end

   assign bus.grant       = w_grant;
   assign bus.grant_idx   = r_idx;
   assign bus.grant_valid = r_valid;
`ifdef HOLD_LIMIT_EN
   assign bus.timeout     = r_timeout;
`else
   assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_week6_ex1_rr_arbiter.sv
// Bench for the round-robin arbiter: directed scenarios plus random req against a behavioural model.
module tb_week6_ex1_rr_arbiter;
   localparam int MAXH = 4;

   logic clk = 1'b0;
   logic rst;
   week6_ex1_rr_arbiter_if arb_if();

   week6_ex1_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (arb_if)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;
   int   m_valid = 0, m_idx = 0, m_last = 3, m_hold = 0, m_to = 0;
   logic [3:0] m_req;
   logic [3:0] r_stim;

   function automatic int pick(input logic [3:0] r, input int base);
      for (int k = 1; k <= 4; k++) if (r[(base + k) % 4]) return (base + k) % 4;
      return base;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the resource after each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_idx = 0; m_last = 3; m_hold = 0; m_to = 0;
      end else begin
         m_req = arb_if.req;
         m_to  = 0;
         if (m_valid == 0) begin
            if (m_req != 0) begin
               m_idx = pick(m_req, m_last); m_last = m_idx; m_valid = 1; m_hold = 1;
            end
         end else if (m_req[m_idx]) begin
`ifdef HOLD_LIMIT_EN
            if (m_hold == MAXH && (m_req & ~(4'(1) << m_idx)) != 0) begin
               m_idx = pick(m_req & ~(4'(1) << m_idx), m_idx);
               m_last = m_idx; m_hold = 1; m_to = 1;
            end else if (m_hold < MAXH) m_hold++;
`else
            if (m_hold < 255) m_hold++;
`endif
         end else if (m_req != 0) begin
            m_idx = pick(m_req, m_idx); m_last = m_idx; m_hold = 1;
         end else begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_grant", arb_if.grant, (m_valid != 0) ? (1 << m_idx) : 0);
         check("model_valid", arb_if.grant_valid, m_valid);
         check("model_idx", arb_if.grant_idx, m_idx);
         check("model_timeout", arb_if.timeout, m_to);
      end
   end

   task automatic cyc(input logic [3:0] r);
      @(negedge clk);
      arb_if.req = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      arb_if.req = 4'b1111;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      #1;
      check("rst_grant", arb_if.grant, 0);
      check("rst_valid", arb_if.grant_valid, 0);
      check("rst_timeout", arb_if.timeout, 0);
      check("rst_idx", arb_if.grant_idx, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("first_grant", arb_if.grant, 4'b0001);
      check("first_idx", arb_if.grant_idx, 0);

      cyc(4'b1110); check("rot_1", arb_if.grant, 4'b0010);
      cyc(4'b1111); check("rot_hold", arb_if.grant, 4'b0010);
      cyc(4'b1101); check("rot_2", arb_if.grant, 4'b0100);
      cyc(4'b1011); check("rot_3", arb_if.grant, 4'b1000);
      cyc(4'b0111); check("rot_0", arb_if.grant, 4'b0001);

      cyc(4'b0100); check("wrap_own2", arb_if.grant, 4'b0100);
      cyc(4'b1001); check("wrap_to3", arb_if.grant, 4'b1000);
      cyc(4'b0001); check("wrap_to0", arb_if.grant, 4'b0001);

      cyc(4'b0000); check("idle_valid", arb_if.grant_valid, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(4'b0100); check("pulse_grant", arb_if.grant, 4'b0100);
      end
      cyc(4'b0000);
      check("pulse_end_grant", arb_if.grant, 0);
      check("pulse_end_valid", arb_if.grant_valid, 0);
      check("pulse_end_idx", arb_if.grant_idx, 2);

      cyc(4'b0010); check("pre_rst_grant", arb_if.grant, 4'b0010);
      cyc(4'b0010);
      @(negedge clk); #2 rst = 1'b1; #1;
      check("async_rst_grant", arb_if.grant, 0);
      check("async_rst_valid", arb_if.grant_valid, 0);
      @(negedge clk) arb_if.req = 4'b0000;
      @(negedge clk) rst = 1'b0;
      cyc(4'b0010);
      check("post_rst_grant", arb_if.grant, 4'b0010);
      check("post_rst_idx", arb_if.grant_idx, 1);

      cyc(4'b0000);
      for (int e = 1; e <= 12; e++) begin
         cyc(4'b0011);
`ifdef HOLD_LIMIT_EN
         check("hold_lim_grant", arb_if.grant, (((e - 1) / 4) % 2 != 0) ? 4'b0010 : 4'b0001);
         check("hold_lim_timeout", arb_if.timeout, (e == 5 || e == 9) ? 1 : 0);
`else
         check("hold_nolim_grant", arb_if.grant, 4'b0001);
         check("hold_nolim_timeout", arb_if.timeout, 0);
`endif
      end
      for (int e = 0; e < 20; e++) begin
         cyc(4'b0001);
         check("solo_grant", arb_if.grant, 4'b0001);
         check("solo_timeout", arb_if.timeout, 0);
      end

      r_stim = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            @(negedge clk); #3 rst = 1'b1; #1;
            check("rand_rst_grant", arb_if.grant, 0);
            @(negedge clk) rst = 1'b0;
         end else begin
            case ($urandom_range(0, 5))
               0: r_stim = 4'($urandom);
               1, 2, 3: r_stim = r_stim;
               4: r_stim = r_stim & ~(4'(1) << m_idx);
               default: r_stim = 4'(1) << $urandom_range(0, 3);
            endcase
            cyc(r_stim);
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
